spi_reg_loader: RTL and testbench



---
 rtl/spi_reg_pkg.sv | 19 +
 rtl/spi_sync.sv | 32 +++
 rtl/spi_reg_loader.sv | 147 ++++++++++++++
 tb/tb_spi_reg_loader.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register loader: FSM states, frame field
// positions and bank size.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    HOLD   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int NUM_REGS   = 4;
  localparam int RW_BIT     = 15;
  localparam int ADDR_HI    = 9;
  localparam int ADDR_LO    = 8;
  localparam int DATA_HI    = 7;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with one-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_reg;
  logic              prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_reg <= {STAGES{IDLE_VAL}};
      prev_reg  <= IDLE_VAL;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], din};
      prev_reg  <= chain_reg[STAGES-1];
    end
  end

  assign dout = chain_reg[STAGES-1];
  assign rise = dout & ~prev_reg;
  assign fall = ~dout & prev_reg;

endmodule

// File: rtl/spi_reg_loader.sv
// SPI mode-0 slave that receives 16-bit write/read frames, keeps a 4-entry
// shadow of the bank and drives a registered select/load pair on writes.
module spi_reg_loader
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SCLK,
  input  logic       SCS_N,
  input  logic       SDI,
  output logic       SDO,
  output logic [0:7] PLD,
  output logic [0:1] RSELIN,
  output logic       BUSY,
  output logic       FRAME_ERR
);

  if (FRAME_BITS != 16) begin : g_bad_frame_bits
    $error("spi_reg_loader: FRAME_BITS must be 16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("spi_reg_loader: SYNC_STAGES must be at least 2");
  end

  localparam int WW = $clog2(SYNC_STAGES + 2);

  logic sclk_s, sclk_rise, sclk_fall;
  logic sdi_s, sdi_rise, sdi_fall;
  logic cs_s, cs_rise, cs_fall;

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
    .clk(CLK), .rst_n(RST_N), .din(SCLK),
    .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sdi (
    .clk(CLK), .rst_n(RST_N), .din(SDI),
    .dout(sdi_s), .rise(sdi_rise), .fall(sdi_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cs (
    .clk(CLK), .rst_n(RST_N), .din(SCS_N),
    .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  logic unused_sync;
  assign unused_sync = &{sclk_s, sdi_rise, sdi_fall, cs_fall, 1'b0};

  state_t        state_reg, state_next;
  logic [4:0]    cnt_reg;
  logic [15:0]   rx_reg;
  logic [7:0]    tx_reg;
  logic [7:0]    shadow_reg [NUM_REGS];
  logic [7:0]    pld_reg;
  logic [1:0]    rsel_reg;
  logic          frame_err_reg;
  logic [WW-1:0] warm_reg;
  logic          armed_reg;
  logic          warm_done;

  // The synchronizers read idle levels for a few cycles after reset; a host
  // already mid-frame must not look like a fresh CS fall, so a frame may
  // only start once CS has really been seen high.
  assign warm_done = (warm_reg == WW'(SYNC_STAGES + 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      warm_reg  <= '0;
      armed_reg <= 1'b0;
    end else begin
      if (!warm_done) warm_reg <= warm_reg + WW'(1);
      if (warm_done && cs_s) armed_reg <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (armed_reg && !cs_s) state_next = SHIFT;
      SHIFT: begin
        if (cs_rise)                              state_next = IDLE;
        else if (sclk_rise && cnt_reg == 5'd15)   state_next = HOLD;
      end
      HOLD:    if (cs_rise) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_reg       <= '0;
      rx_reg        <= '0;
      tx_reg        <= '0;
      pld_reg       <= '0;
      rsel_reg      <= '0;
      frame_err_reg <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) shadow_reg[i] <= '0;
    end else begin
      frame_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (state_next == SHIFT) begin
            cnt_reg <= '0;
            rx_reg  <= '0;
            tx_reg  <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            frame_err_reg <= 1'b1;
            tx_reg        <= '0;
          end else if (sclk_rise) begin
            rx_reg  <= {rx_reg[14:0], sdi_s};
            cnt_reg <= cnt_reg + 5'd1;
            // Eighth bit arriving now: rx_reg[0] holds ADDR_HI, SDI is ADDR_LO.
            if (cnt_reg == 5'd7)  tx_reg <= shadow_reg[{rx_reg[0], sdi_s}];
            if (cnt_reg == 5'd15) tx_reg <= '0;
          end else if (sclk_fall && cnt_reg >= 5'd9) begin
            tx_reg <= {tx_reg[6:0], 1'b0};
          end
        end
        COMMIT: begin
          if (rx_reg[RW_BIT]) begin
            shadow_reg[rx_reg[ADDR_HI:ADDR_LO]] <= rx_reg[DATA_HI:0];
            pld_reg  <= rx_reg[DATA_HI:0];
            rsel_reg <= rx_reg[ADDR_HI:ADDR_LO];
          end
        end
        default: ;
      endcase
    end
  end

  assign SDO       = tx_reg[7];
  assign PLD       = pld_reg;
  assign RSELIN    = rsel_reg;
  assign BUSY      = (state_reg == SHIFT) || (state_reg == HOLD);
  assign FRAME_ERR = frame_err_reg;

endmodule

// File: tb/tb_spi_reg_loader.sv
// Directed bench for spi_reg_loader: writes, readback, abort, reset mid-frame
// and back-to-back frames at SCLK = CLK/8.
module tb_spi_reg_loader;

  logic       CLK = 1'b0;
  logic       RST_N, SCLK, SCS_N, SDI;
  logic       SDO, BUSY, FRAME_ERR;
  logic [0:7] PLD;
  logic [0:1] RSELIN;

  int checks = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int bad_pair = 0;

  spi_reg_loader #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .SCLK(SCLK), .SCS_N(SCS_N), .SDI(SDI),
    .SDO(SDO), .PLD(PLD), .RSELIN(RSELIN), .BUSY(BUSY), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Watch n CLK cycles for FRAME_ERR pulses and the forbidden 3/0x3C pairing.
  task automatic settle(input int n);
    repeat (n) begin
      @(negedge CLK);
      if (FRAME_ERR === 1'b1) ferr_cnt++;
      if (RSELIN == 2'd3 && PLD == 8'h3C) bad_pair++;
    end
  endtask

  task automatic cs_low();
    @(negedge CLK);
    SCS_N = 1'b0;
  endtask

  task automatic cs_high();
    repeat (4) @(negedge CLK);
    SCS_N = 1'b1;
  endtask

  // Bits first..last of word, MSB first; SDO captured just before each rise.
  task automatic spi_bits(input logic [15:0] word, input int first, input int last,
                          output logic [7:0] rd, output logic pre);
    rd  = '0;
    pre = 1'b0;
    for (int i = first; i <= last; i++) begin
      SDI = word[15-i];
      repeat (4) @(negedge CLK);
      if (i >= 8) rd[15-i] = SDO;
      else        pre = pre | SDO;
      SCLK = 1'b1;
      repeat (4) @(negedge CLK);
      SCLK = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] word, input int nbits,
                       output logic [7:0] rd, output logic pre);
    cs_low();
    spi_bits(word, 0, nbits - 1, rd, pre);
    cs_high();
  endtask

  logic [7:0] rd;
  logic       pre;

  initial begin
    RST_N = 1'b0; SCLK = 1'b0; SCS_N = 1'b1; SDI = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_pld", 32'(PLD), 32'h00);
    chk("rst_rsel", 32'(RSELIN), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_sdo", 32'(SDO), 32'h0);
    chk("rst_ferr", 32'(FRAME_ERR), 32'h0);
    RST_N = 1'b1;
    repeat (6) @(negedge CLK);

    // Write ADDR2 = 0xA5, exact commit latency after CS rise
    ferr_cnt = 0;
    cs_low();
    spi_bits(16'h82A5, 0, 15, rd, pre);
    chk("w1_readback_prewrite", 32'(rd), 32'h00);
    chk("w1_sdo_before_data", 32'(pre), 32'h0);
    cs_high();
    @(negedge CLK);
    @(negedge CLK);
    chk("w1_busy_hold", 32'(BUSY), 32'h1);
    @(negedge CLK);
    chk("w1_busy_commit", 32'(BUSY), 32'h0);
    chk("w1_pld_not_yet", 32'(PLD), 32'h00);
    @(negedge CLK);
    chk("w1_pld", 32'(PLD), 32'hA5);
    chk("w1_rsel", 32'(RSELIN), 32'h2);
    settle(6);
    chk("w1_no_ferr", 32'(ferr_cnt), 32'h0);

    // Write ADDR1 = 0x3C then ADDR3 = 0x81, never pairing 3 with 0x3C
    bad_pair = 0;
    frame(16'h813C, 16, rd, pre);
    settle(8);
    chk("w2_rsel", 32'(RSELIN), 32'h1);
    chk("w2_pld", 32'(PLD), 32'h3C);
    frame(16'h8381, 16, rd, pre);
    settle(8);
    chk("w3_rsel", 32'(RSELIN), 32'h3);
    chk("w3_pld", 32'(PLD), 32'h81);
    chk("w3_atomic_pair", 32'(bad_pair), 32'h0);

    // Read ADDR1
    frame(16'h0100, 16, rd, pre);
    settle(8);
    chk("r1_readback", 32'(rd), 32'h3C);
    chk("r1_rsel_hold", 32'(RSELIN), 32'h3);
    chk("r1_pld_hold", 32'(PLD), 32'h81);
    chk("idle_sdo", 32'(SDO), 32'h0);
    chk("r1_no_ferr", 32'(ferr_cnt), 32'h0);

    // Abort after 9 rises, then normal frames
    ferr_cnt = 0;
    frame(16'h81EE, 9, rd, pre);
    settle(8);
    chk("ab_ferr_pulses", 32'(ferr_cnt), 32'h1);
    chk("ab_pld", 32'(PLD), 32'h81);
    chk("ab_rsel", 32'(RSELIN), 32'h3);
    frame(16'h0100, 16, rd, pre);
    settle(8);
    chk("ab_shadow_kept", 32'(rd), 32'h3C);
    frame(16'h805A, 16, rd, pre);
    settle(8);
    chk("ab_next_pld", 32'(PLD), 32'h5A);
    chk("ab_next_rsel", 32'(RSELIN), 32'h0);
    chk("ab_no_more_ferr", 32'(ferr_cnt), 32'h1);

    // Reset asserted at bit 12 of a write frame
    cs_low();
    spi_bits(16'h8355, 0, 11, rd, pre);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_pld", 32'(PLD), 32'h00);
    chk("mid_rst_rsel", 32'(RSELIN), 32'h0);
    chk("mid_rst_busy", 32'(BUSY), 32'h0);
    chk("mid_rst_sdo", 32'(SDO), 32'h0);
    chk("mid_rst_ferr", 32'(FRAME_ERR), 32'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    ferr_cnt = 0;
    spi_bits(16'h8355, 12, 15, rd, pre);
    cs_high();
    settle(10);
    chk("post_rst_pld", 32'(PLD), 32'h00);
    chk("post_rst_rsel", 32'(RSELIN), 32'h0);
    chk("post_rst_no_ferr", 32'(ferr_cnt), 32'h0);
    frame(16'h0300, 16, rd, pre);
    settle(8);
    chk("post_rst_shadow3", 32'(rd), 32'h00);

    // Back-to-back writes with a 4-CLK CS-high gap
    cs_low();
    spi_bits(16'h8011, 0, 15, rd, pre);
    cs_high();
    repeat (3) @(negedge CLK);
    chk("b2b_busy_gap", 32'(BUSY), 32'h0);
    @(negedge CLK);
    chk("b2b_first_pld", 32'(PLD), 32'h11);
    chk("b2b_first_rsel", 32'(RSELIN), 32'h0);
    SCS_N = 1'b0;
    spi_bits(16'h8022, 0, 15, rd, pre);
    cs_high();
    settle(8);
    chk("b2b_second_readback", 32'(rd), 32'h11);
    chk("b2b_second_pld", 32'(PLD), 32'h22);
    chk("b2b_second_rsel", 32'(RSELIN), 32'h0);
    chk("b2b_no_ferr", 32'(ferr_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
